// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N requesters.
// Each grant clamps the operand to 9999, starts the converter and waits on it under a watchdog.
module bcd_conv_arbiter #(
    parameter int N       = 4,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req,
    input  logic [14*N-1:0]   req_bin,
    output logic [N-1:0]      done_vec,
    output logic [N-1:0]      err_vec,
    output logic [15:0]       bcd_out,
    output logic [IDXW-1:0]   grant_idx,
    output logic              busy,
    output logic              conv_start,
    output logic [13:0]       conv_bin,
    input  logic              conv_ready,
    input  logic              conv_done_tick,
    input  logic [3:0]        conv_bcd3,
    input  logic [3:0]        conv_bcd2,
    input  logic [3:0]        conv_bcd1,
    input  logic [3:0]        conv_bcd0
);

    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [13:0]     bin_q, bin_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            tout_q, tout_d;

    logic            found;
    logic [IDXW-1:0] win;
    int              cand;

    function automatic logic [13:0] clamp9999(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    // First asserted request strictly after the last grant, wrapping mod N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_q) + k;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = IDXW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        wdog_d  = wdog_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE: begin
                if (found && conv_ready) begin
                    grant_d = win;
                    bin_d   = clamp9999(req_bin[14*int'(win) +: 14]);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A done tick on the watchdog's last cycle still counts as success.
                if (conv_done_tick) begin
                    bcd_d   = {conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0};
                    state_d = DELIVER;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    bcd_d   = 16'h0000;
                    tout_d  = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                tout_d  = 1'b0;
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= IDXW'(N - 1);
            last_q  <= IDXW'(N - 1);
            bin_q   <= '0;
            bcd_q   <= '0;
            wdog_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            wdog_q  <= wdog_d;
            tout_q  <= tout_d;
        end
    end

    logic [N-1:0] grant_onehot;
    assign grant_onehot = N'(1) << grant_q;

    assign done_vec   = (state_q == DELIVER) ? grant_onehot : '0;
    assign err_vec    = (state_q == DELIVER && tout_q) ? grant_onehot : '0;
    assign bcd_out    = bcd_q;
    assign grant_idx  = grant_q;
    assign busy       = (state_q != IDLE);
    assign conv_start = (state_q == ISSUE);
    assign conv_bin   = bin_q;

endmodule
